vend_txn_ctrl: RTL and testbench
================================

VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 Parameters SHALL be:
  ID_W, 10, item identifier width
  CUR_W, 8, coin value width
  CREDIT_W, 16, credit/cost/change width (>= CUR_W+1)
  TIMEOUT_CYC, 1000, idle-money timeout in clk cycles (>= 2)
REQ-002 Ports SHALL be:
  clk  in  1  clock, rising edge
  rstn  in  1  reset, asynchronous, active-low
  cfg_mode  in  1  configuration mode; vending inhibited
  coin_valid  in  1  coin strobe, one cycle per coin
  coin_value  in  CUR_W  coin value
  coin_reject  out  1  one-cycle pulse: coin not accepted
  sel_valid  in  1  item-select strobe
  sel_id  in  ID_W  selected item
  cancel  in  1  refund request strobe
  cfg_rd_req  out  1  item lookup request, held until ack
  cfg_item_id  out  ID_W  item for lookup/update
  cfg_rd_ack  in  1  lookup data valid
  cfg_item_cost  in  CREDIT_W  cost, valid with ack
  cfg_item_avail  in  CUR_W  stock count, valid with ack
  cfg_upd_req  out  1  one-cycle pulse: decrement stock of cfg_item_id
  disp_valid  out  1  dispense request
  disp_id  out  ID_W  item to dispense
  disp_ready  in  1  dispenser accepts
  chg_valid  out  1  change/refund request
  chg_amount  out  CREDIT_W  change/refund amount
  chg_ready  in  1  changer accepts
  sold_out  out  1  one-cycle pulse: selected item stock is 0
  busy  out  1  state != IDLE

Function
REQ-003 States SHALL be IDLE, CFG_RD, WAIT_MONEY, DISPENSE, CHANGE; all outputs except pulses decoded from registered state/data.
REQ-004 IDLE: sel_valid with cfg_mode=0 SHALL latch sel_id and go to CFG_RD; cancel with credit>0 SHALL go to CHANGE; cfg_mode=1 SHALL ignore sel_valid and cancel.
REQ-005 CFG_RD: cfg_rd_req=1, cfg_item_id=latched id until cfg_rd_ack; on ack latch cost; avail=0 -> sold_out pulse, return IDLE, credit kept; else go WAIT_MONEY.
REQ-006 Coins SHALL be accepted only in IDLE (cfg_mode=0), CFG_RD and WAIT_MONEY; credit += coin_value next edge.
REQ-007 Coin that would exceed 2^CREDIT_W-1, or arrives in DISPENSE/CHANGE or with cfg_mode=1, SHALL be rejected: credit unchanged, coin_reject pulse next cycle.
REQ-008 WAIT_MONEY: registered credit >= cost SHALL go DISPENSE next cycle; a coin arriving the same cycle is added but compared the following cycle.
REQ-009 WAIT_MONEY: timeout counter SHALL clear on entry and on each accepted coin; on reaching TIMEOUT_CYC-1 go CHANGE if credit>0 else IDLE.
REQ-010 WAIT_MONEY: cancel SHALL go CHANGE (credit>0) or IDLE (credit=0) and has priority over credit>=cost and timeout.
REQ-011 DISPENSE: disp_valid=1, disp_id stable until disp_ready; on handshake cfg_upd_req pulses one cycle, credit <= credit - cost, next state CHANGE if remainder>0 else IDLE.
REQ-012 CHANGE: chg_valid=1, chg_amount=credit stable until chg_ready; on handshake credit <= 0, go IDLE.
REQ-013 cancel, sel_valid and cfg_mode SHALL be ignored in DISPENSE and CHANGE; sel_valid ignored outside IDLE.
REQ-014 Credit arithmetic SHALL be unsigned CREDIT_W, coin zero-extended; no wrap.

Reset
REQ-015 rstn low SHALL force IDLE, credit 0, timeout 0, latched id/cost 0, all outputs 0, asynchronously.
REQ-016 Reset mid-transaction SHALL discard credit with no refund and no dispense.

Structure
REQ-017 Package vend_pkg SHALL hold state enum and default width/timeout constants.
REQ-018 Credit accumulator with saturation check SHALL be sub-module vend_credit_acc (add, subtract, clear, reject flag).

Verification
REQ-019 Select id 5 (cost 30, avail 3), coins 10,10,20 -> DISPENSE id 5, one cfg_upd_req, chg_amount 10, IDLE.
REQ-020 Select id 2 with avail 0 after coin 20 -> sold_out pulse, IDLE, credit 20 retained; cancel -> chg_amount 20.
REQ-021 TIMEOUT_CYC=16, select (cost 50), coin 20, no further input -> CHANGE 20 exactly 16 cycles after coin.
REQ-022 Credit 65530, coin 10 -> coin_reject, credit 65530; coin during DISPENSE -> coin_reject.
REQ-023 Exact-pay cost 40 with coins 20,20, disp_ready held low 5 cycles -> disp_valid/disp_id stable, no CHANGE, IDLE after handshake.
REQ-024 Reset asserted in CHANGE -> outputs 0 immediately, credit 0, no chg handshake after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending
// transaction controller.
package vend_pkg;

  localparam int ID_W_DEF     = 10;
  localparam int CUR_W_DEF    = 8;
  localparam int CREDIT_W_DEF = 16;
  localparam int TMO_CYC_DEF  = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_RD,
    S_WAIT_MONEY,
    S_DISPENSE,
    S_CHANGE
  } state_t;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: saturation-checked add, subtract of
// cost on dispense, and clear on refund.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CUR_W    = CUR_W_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                add_en,
  input  logic [CUR_W-1:0]    add_val,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_val,
  input  logic                clr,
  output logic [CREDIT_W-1:0] credit,
  output logic                ovf
);

  logic [CREDIT_W:0] sum;

  // One extra bit exposes a sum that no longer fits.
  assign sum = {1'b0, credit}
             + {{(CREDIT_W+1-CUR_W){1'b0}}, add_val};
  assign ovf = sum[CREDIT_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit <= '0;
    end else if (clr) begin
      credit <= '0;
    end else if (sub_en) begin
      credit <= credit - sub_val;
    end else if (add_en && !ovf) begin
      credit <= sum[CREDIT_W-1:0];
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: select, lookup, collect,
// dispense and refund around a saturating credit register.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int CUR_W       = CUR_W_DEF,
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int TIMEOUT_CYC = TMO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_mode,
  input  logic                coin_valid,
  input  logic [CUR_W-1:0]    coin_value,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  output logic                cfg_rd_req,
  output logic [ID_W-1:0]     cfg_item_id,
  input  logic                cfg_rd_ack,
  input  logic [CREDIT_W-1:0] cfg_item_cost,
  input  logic [CUR_W-1:0]    cfg_item_avail,
  output logic                cfg_upd_req,
  output logic                disp_valid,
  output logic [ID_W-1:0]     disp_id,
  input  logic                disp_ready,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amount,
  input  logic                chg_ready,
  output logic                sold_out,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t              state, state_n;
  logic [ID_W-1:0]     id_q;
  logic [CREDIT_W-1:0] cost_q;
  logic [TW-1:0]       tmo_q;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] rem;
  logic                ovf;
  logic                coin_ok;
  logic                coin_acc;
  logic                disp_hs;
  logic                chg_hs;
  logic                credit_nz;
  logic                tmo_hit;

  assign coin_ok = coin_valid && !cfg_mode
                && (state == S_IDLE
                 || state == S_CFG_RD
                 || state == S_WAIT_MONEY);
  assign coin_acc  = coin_ok && !ovf;
  assign disp_hs   = (state == S_DISPENSE) && disp_ready;
  assign chg_hs    = (state == S_CHANGE) && chg_ready;
  assign credit_nz = (credit != '0);
  assign rem       = credit - cost_q;
  // A coin landing on the last idle cycle restarts the wait.
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYC - 1))
                  && !coin_acc;

  vend_credit_acc #(
    .CUR_W    (CUR_W),
    .CREDIT_W (CREDIT_W)
  ) u_acc (
    .clk     (clk),
    .rstn    (rstn),
    .add_en  (coin_acc),
    .add_val (coin_value),
    .sub_en  (disp_hs),
    .sub_val (cost_q),
    .clr     (chg_hs),
    .credit  (credit),
    .ovf     (ovf)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (!cfg_mode) begin
          if (sel_valid)
            state_n = S_CFG_RD;
          else if (cancel && credit_nz)
            state_n = S_CHANGE;
        end
      end
      S_CFG_RD: begin
        if (cfg_rd_ack)
          state_n = (cfg_item_avail == '0)
                  ? S_IDLE : S_WAIT_MONEY;
      end
      S_WAIT_MONEY: begin
        if (cancel)
          state_n = credit_nz ? S_CHANGE : S_IDLE;
        else if (credit >= cost_q)
          state_n = S_DISPENSE;
        else if (tmo_hit)
          state_n = credit_nz ? S_CHANGE : S_IDLE;
      end
      S_DISPENSE: begin
        if (disp_ready)
          state_n = (rem != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (chg_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      id_q        <= '0;
      cost_q      <= '0;
      tmo_q       <= '0;
      coin_reject <= 1'b0;
      sold_out    <= 1'b0;
      cfg_upd_req <= 1'b0;
    end else begin
      state       <= state_n;
      coin_reject <= coin_valid && !coin_acc;
      sold_out    <= (state == S_CFG_RD) && cfg_rd_ack
                  && (cfg_item_avail == '0);
      cfg_upd_req <= disp_hs;
      if (state == S_IDLE && !cfg_mode && sel_valid)
        id_q <= sel_id;
      if (state == S_CFG_RD && cfg_rd_ack)
        cost_q <= cfg_item_cost;
      if (state != S_WAIT_MONEY || coin_acc)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

  assign busy        = (state != S_IDLE);
  assign cfg_rd_req  = (state == S_CFG_RD);
  assign cfg_item_id = id_q;
  assign disp_valid  = (state == S_DISPENSE);
  assign disp_id     = disp_valid ? id_q : '0;
  assign chg_valid   = (state == S_CHANGE);
  assign chg_amount  = chg_valid ? credit : '0;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed scenarios plus random
// purchases checked against a transaction-level model.
module tb_vend_txn_ctrl;

  localparam int ID_W     = 10;
  localparam int CUR_W    = 8;
  localparam int CREDIT_W = 16;
  localparam int TMO      = 16;

  logic                clk = 1'b0;
  logic                rstn;
  logic                cfg_mode;
  logic                coin_valid;
  logic [CUR_W-1:0]    coin_value;
  logic                coin_reject;
  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;
  logic                cancel;
  logic                cfg_rd_req;
  logic [ID_W-1:0]     cfg_item_id;
  logic                cfg_rd_ack;
  logic [CREDIT_W-1:0] cfg_item_cost;
  logic [CUR_W-1:0]    cfg_item_avail;
  logic                cfg_upd_req;
  logic                disp_valid;
  logic [ID_W-1:0]     disp_id;
  logic                disp_ready;
  logic                chg_valid;
  logic [CREDIT_W-1:0] chg_amount;
  logic                chg_ready;
  logic                sold_out;
  logic                busy;

  int total = 0;
  int bad   = 0;

  int cost_tab[16];
  int avail_tab[16];
  int rd_lat = 0;
  int disp_stall = 0;
  int chg_stall = 0;
  int n_sold = 0;
  int n_rej = 0;
  int n_upd = 0;
  int disp_q[$];
  int chg_q[$];

  vend_txn_ctrl #(
    .ID_W        (ID_W),
    .CUR_W       (CUR_W),
    .CREDIT_W    (CREDIT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_mode       (cfg_mode),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .coin_reject    (coin_reject),
    .sel_valid      (sel_valid),
    .sel_id         (sel_id),
    .cancel         (cancel),
    .cfg_rd_req     (cfg_rd_req),
    .cfg_item_id    (cfg_item_id),
    .cfg_rd_ack     (cfg_rd_ack),
    .cfg_item_cost  (cfg_item_cost),
    .cfg_item_avail (cfg_item_avail),
    .cfg_upd_req    (cfg_upd_req),
    .disp_valid     (disp_valid),
    .disp_id        (disp_id),
    .disp_ready     (disp_ready),
    .chg_valid      (chg_valid),
    .chg_amount     (chg_amount),
    .chg_ready      (chg_ready),
    .sold_out       (sold_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Item memory, dispenser and changer, all acting on negedges.
  initial begin
    int rd_wait;
    int d_cnt;
    int c_cnt;
    rd_wait = 0;
    d_cnt = 0;
    c_cnt = 0;
    cfg_rd_ack = 0;
    cfg_item_cost = '0;
    cfg_item_avail = '0;
    disp_ready = 0;
    chg_ready = 0;
    forever begin
      @(negedge clk);
      cfg_rd_ack = 0;
      disp_ready = 0;
      chg_ready = 0;
      if (sold_out) n_sold++;
      if (coin_reject) n_rej++;
      if (cfg_upd_req) begin
        n_upd++;
        if (avail_tab[cfg_item_id[3:0]] > 0)
          avail_tab[cfg_item_id[3:0]]--;
      end
      if (cfg_rd_req) begin
        if (rd_wait >= rd_lat) begin
          cfg_rd_ack = 1;
          cfg_item_cost =
            CREDIT_W'(cost_tab[cfg_item_id[3:0]]);
          cfg_item_avail =
            CUR_W'(avail_tab[cfg_item_id[3:0]]);
          rd_wait = 0;
        end else rd_wait++;
      end else rd_wait = 0;
      if (disp_valid) begin
        if (d_cnt >= disp_stall) begin
          disp_ready = 1;
          disp_q.push_back(int'(disp_id));
          d_cnt = 0;
        end else d_cnt++;
      end else d_cnt = 0;
      if (chg_valid) begin
        if (c_cnt >= chg_stall) begin
          chg_ready = 1;
          chg_q.push_back(int'(chg_amount));
          c_cnt = 0;
        end else c_cnt++;
      end else c_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin(int v);
    coin_valid = 1;
    coin_value = CUR_W'(v);
    step();
    coin_valid = 0;
  endtask

  task automatic sel(int id);
    sel_valid = 1;
    sel_id = ID_W'(id);
    step();
    sel_valid = 0;
  endtask

  task automatic do_cancel;
    cancel = 1;
    step();
    cancel = 0;
  endtask

  task automatic wait_idle(output bit to);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      step();
      k++;
    end
    to = (busy !== 1'b0);
  endtask

  task automatic test_reset;
    rstn = 0;
    step(2);
    total++;
    if ({busy, cfg_rd_req, disp_valid, chg_valid,
         coin_reject, sold_out, cfg_upd_req} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0000000",
        {busy, cfg_rd_req, disp_valid, chg_valid,
         coin_reject, sold_out, cfg_upd_req});
    end
    total++;
    if (chg_amount !== 0 || disp_id !== 0
        || cfg_item_id !== 0) begin
      bad++;
      $display("FAIL reset_data: amt=%0d disp=%0d id=%0d want 0",
        chg_amount, disp_id, cfg_item_id);
    end
    rstn = 1;
    step(2);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_purchase;
    bit to;
    int u0;
    cost_tab[5] = 30;
    avail_tab[5] = 3;
    rd_lat = 1;
    disp_stall = 0;
    chg_stall = 1;
    disp_q.delete();
    chg_q.delete();
    u0 = n_upd;
    sel(5);
    coin(10);
    coin(10);
    coin(20);
    wait_idle(to);
    step(2);
    total++;
    if (to) begin
      bad++;
      $display("FAIL purchase_idle: busy=%b want 0", busy);
    end
    total++;
    if (disp_q.size() != 1 || disp_q[0] != 5) begin
      bad++;
      $display("FAIL purchase_disp: n=%0d want one item id 5",
        disp_q.size());
    end
    total++;
    if (chg_q.size() != 1 || chg_q[0] != 10) begin
      bad++;
      $display("FAIL purchase_chg: n=%0d first=%0d want 10",
        chg_q.size(), chg_q.size() ? chg_q[0] : -1);
    end
    total++;
    if (n_upd - u0 != 1 || avail_tab[5] != 2) begin
      bad++;
      $display("FAIL purchase_upd: pulses=%0d stock=%0d want 1,2",
        n_upd - u0, avail_tab[5]);
    end
  endtask

  task automatic test_sold_out;
    bit to;
    int s0;
    cost_tab[2] = 25;
    avail_tab[2] = 0;
    rd_lat = 2;
    chg_stall = 0;
    disp_q.delete();
    chg_q.delete();
    s0 = n_sold;
    coin(20);
    sel(2);
    wait_idle(to);
    step(2);
    total++;
    if (to || n_sold - s0 != 1) begin
      bad++;
      $display("FAIL soldout_pulse: pulses=%0d busy=%b want 1,0",
        n_sold - s0, busy);
    end
    total++;
    if (disp_q.size() != 0 || chg_q.size() != 0) begin
      bad++;
      $display("FAIL soldout_quiet: disp=%0d chg=%0d want 0,0",
        disp_q.size(), chg_q.size());
    end
    do_cancel;
    wait_idle(to);
    step(1);
    total++;
    if (to || chg_q.size() != 1 || chg_q[0] != 20) begin
      bad++;
      $display("FAIL soldout_refund: n=%0d amt=%0d want 20",
        chg_q.size(), chg_q.size() ? chg_q[0] : -1);
    end
  endtask

  task automatic test_timeout;
    bit to;
    int k;
    int seen;
    int amt;
    cost_tab[7] = 50;
    avail_tab[7] = 2;
    rd_lat = 0;
    chg_stall = 0;
    chg_q.delete();
    sel(7);
    k = 0;
    while (cfg_rd_req && k < 20) begin
      step();
      k++;
    end
    coin(20);
    seen = 0;
    amt = -1;
    for (int i = 1; i <= 40 && seen == 0; i++) begin
      step();
      if (chg_valid) begin
        seen = i;
        amt = int'(chg_amount);
      end
    end
    total++;
    if (seen != TMO) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d want %0d",
        seen, TMO);
    end
    total++;
    if (amt != 20) begin
      bad++;
      $display("FAIL timeout_amount: got %0d want 20", amt);
    end
    wait_idle(to);
    step(1);
    total++;
    if (to || chg_q.size() != 1) begin
      bad++;
      $display("FAIL timeout_refund: n=%0d busy=%b want 1,0",
        chg_q.size(), busy);
    end
  endtask

  task automatic test_saturate;
    bit to;
    int r0;
    chg_q.delete();
    for (int i = 0; i < 256; i++) coin(255);
    coin(250);
    r0 = n_rej;
    coin(10);
    total++;
    if (coin_reject !== 1'b1) begin
      bad++;
      $display("FAIL sat_reject: got %b want 1", coin_reject);
    end
    coin(5);
    total++;
    if (coin_reject !== 1'b0) begin
      bad++;
      $display("FAIL sat_fill: reject=%b want 0", coin_reject);
    end
    step(2);
    total++;
    if (n_rej - r0 != 1) begin
      bad++;
      $display("FAIL sat_pulses: got %0d want 1", n_rej - r0);
    end
    chg_stall = 0;
    do_cancel;
    wait_idle(to);
    step(1);
    total++;
    if (to || chg_q.size() != 1 || chg_q[0] != 65535) begin
      bad++;
      $display("FAIL sat_refund: n=%0d amt=%0d want 65535",
        chg_q.size(), chg_q.size() ? chg_q[0] : -1);
    end
  endtask

  task automatic test_exact_pay;
    bit to;
    int k;
    int u0;
    cost_tab[9] = 40;
    avail_tab[9] = 1;
    rd_lat = 0;
    disp_stall = 5;
    disp_q.delete();
    chg_q.delete();
    u0 = n_upd;
    sel(9);
    coin(20);
    coin(20);
    k = 0;
    while (!disp_valid && k < 20) begin
      step();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (disp_valid !== 1'b1 || disp_id !== 9) begin
        bad++;
        $display("FAIL exact_stall%0d: valid=%b id=%0d want 1,9",
          i, disp_valid, disp_id);
      end
      if (i == 1) begin
        coin_valid = 1;
        coin_value = 10;
      end
      if (i == 2) begin
        coin_valid = 0;
        total++;
        if (coin_reject !== 1'b1) begin
          bad++;
          $display("FAIL exact_coin_rej: got %b want 1",
            coin_reject);
        end
      end
      step();
    end
    wait_idle(to);
    step(2);
    total++;
    if (to || disp_q.size() != 1 || chg_q.size() != 0) begin
      bad++;
      $display("FAIL exact_result: disp=%0d chg=%0d want 1,0",
        disp_q.size(), chg_q.size());
    end
    total++;
    if (n_upd - u0 != 1) begin
      bad++;
      $display("FAIL exact_upd: got %0d want 1", n_upd - u0);
    end
    disp_stall = 0;
    do_cancel;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL exact_credit0: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_change;
    int k;
    int seen;
    int c0;
    chg_stall = 1000;
    coin(30);
    do_cancel;
    k = 0;
    while (!chg_valid && k < 20) begin
      step();
      k++;
    end
    step(2);
    #2 rstn = 0;
    #1;
    total++;
    if (chg_valid !== 1'b0 || busy !== 1'b0
        || chg_amount !== 0) begin
      bad++;
      $display("FAIL rst_chg: valid=%b busy=%b amt=%0d want 0",
        chg_valid, busy, chg_amount);
    end
    step();
    chg_stall = 0;
    rstn = 1;
    c0 = chg_q.size();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (chg_valid || busy || disp_valid) seen++;
    end
    total++;
    if (seen != 0 || chg_q.size() != c0) begin
      bad++;
      $display("FAIL rst_after: active=%0d hs=%0d want 0,0",
        seen, chg_q.size() - c0);
    end
    do_cancel;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_credit: busy=%b want 0", busy);
    end
  endtask

  task automatic test_random;
    bit to;
    bit cxl;
    int m_stock[16];
    int credit;
    int exp_d[$];
    int exp_c[$];
    int exp_sold;
    int u0;
    int s0;
    int r0;
    int id;
    int k;
    int v;
    int ncoin;
    credit = 0;
    exp_sold = 0;
    disp_q.delete();
    chg_q.delete();
    u0 = n_upd;
    s0 = n_sold;
    for (int i = 0; i < 16; i++) begin
      cost_tab[i] = int'($urandom_range(600, 1));
      avail_tab[i] = int'($urandom_range(2, 0));
      m_stock[i] = avail_tab[i];
    end
    for (int t = 0; t < 40; t++) begin
      id = int'($urandom_range(15, 0));
      rd_lat = int'($urandom_range(3, 0));
      disp_stall = int'($urandom_range(3, 0));
      chg_stall = int'($urandom_range(3, 0));
      if ($urandom_range(4, 0) == 0) begin
        r0 = n_rej;
        cfg_mode = 1;
        sel_valid = 1;
        sel_id = ID_W'(id);
        coin_valid = 1;
        coin_value = CUR_W'($urandom_range(255, 1));
        step();
        cfg_mode = 0;
        sel_valid = 0;
        coin_valid = 0;
        total++;
        if (busy !== 1'b0 || coin_reject !== 1'b1) begin
          bad++;
          $display("FAIL rnd_cfgmode%0d: busy=%b rej=%b want 0,1",
            t, busy, coin_reject);
        end
      end
      sel(id);
      k = 0;
      while (cfg_rd_req && k < 20) begin
        step();
        k++;
      end
      if (m_stock[id] == 0) begin
        exp_sold++;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL rnd_sold%0d: busy=%b want 0", t, busy);
        end
        if ($urandom_range(1, 0) == 1 && credit > 0) begin
          do_cancel;
          wait_idle(to);
          exp_c.push_back(credit);
          credit = 0;
        end
      end else begin
        cxl = ($urandom_range(3, 0) == 0);
        ncoin = 0;
        while (credit < cost_tab[id]
               && !(cxl && ncoin == 1)) begin
          step(int'($urandom_range(2, 0)));
          v = int'($urandom_range(255, 1));
          coin(v);
          credit += v;
          ncoin++;
        end
        if (credit < cost_tab[id]) begin
          do_cancel;
          if (credit > 0) exp_c.push_back(credit);
        end else begin
          exp_d.push_back(id);
          m_stock[id]--;
          if (credit > cost_tab[id])
            exp_c.push_back(credit - cost_tab[id]);
        end
        credit = 0;
        wait_idle(to);
      end
      total++;
      if (to || busy !== 1'b0) begin
        bad++;
        $display("FAIL rnd_idle%0d: busy=%b want 0", t, busy);
      end
    end
    if (credit > 0) begin
      do_cancel;
      wait_idle(to);
      exp_c.push_back(credit);
    end
    step(3);
    total++;
    if (disp_q.size() != exp_d.size()) begin
      bad++;
      $display("FAIL rnd_disp_n: got %0d want %0d",
        disp_q.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        total++;
        if (disp_q[i] != exp_d[i]) begin
          bad++;
          $display("FAIL rnd_disp%0d: got %0d want %0d",
            i, disp_q[i], exp_d[i]);
        end
      end
    end
    total++;
    if (chg_q.size() != exp_c.size()) begin
      bad++;
      $display("FAIL rnd_chg_n: got %0d want %0d",
        chg_q.size(), exp_c.size());
    end else begin
      for (int i = 0; i < exp_c.size(); i++) begin
        total++;
        if (chg_q[i] != exp_c[i]) begin
          bad++;
          $display("FAIL rnd_chg%0d: got %0d want %0d",
            i, chg_q[i], exp_c[i]);
        end
      end
    end
    total++;
    if (n_upd - u0 != exp_d.size()
        || n_sold - s0 != exp_sold) begin
      bad++;
      $display("FAIL rnd_pulses: upd=%0d sold=%0d want %0d,%0d",
        n_upd - u0, n_sold - s0, exp_d.size(), exp_sold);
    end
  endtask

  initial begin
    rstn = 0;
    cfg_mode = 0;
    coin_valid = 0;
    coin_value = '0;
    sel_valid = 0;
    sel_id = '0;
    cancel = 0;
    for (int i = 0; i < 16; i++) begin
      cost_tab[i] = 0;
      avail_tab[i] = 0;
    end
    test_reset;
    test_purchase;
    test_sold_out;
    test_timeout;
    test_saturate;
    test_exact_pay;
    test_reset_change;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
